// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives PC strobes, issues one memory read
// at a time and holds the fetched word for decode.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [ADDR_WIDTH-1:0] pcValue,
  output logic [ADDR_WIDTH-1:0] pcDataIn,
  output logic                  pcWriteEnable,
  output logic                  pcCountEnable,
  output logic                  memValid,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic                  memReady,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic                  instrValid,
  output logic [DATA_WIDTH-1:0] instrData,
  output logic [ADDR_WIDTH-1:0] instrPc,
  input  logic                  instrReady,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectTarget,
  output logic                  fault
);

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    HOLD,
    DRAIN,
    FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [ADDR_WIDTH-1:0] instrPc_q, instrPc_d;
  logic [DATA_WIDTH-1:0] instrData_q, instrData_d;
  logic                  fault_q, fault_d;
  logic                  count_d;
  logic                  aligned, redirOk, redirBad;

  assign aligned  = (redirectTarget[1:0] == 2'b00);
  assign redirOk  = redirectValid && aligned;
  assign redirBad = redirectValid && !aligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      memAddr_q   <= '0;
      instrPc_q   <= '0;
      instrData_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      memAddr_q   <= memAddr_d;
      instrPc_q   <= instrPc_d;
      instrData_q <= instrData_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    memAddr_d   = memAddr_q;
    instrPc_d   = instrPc_q;
    instrData_d = instrData_q;
    fault_d     = fault_q;
    count_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirBad) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else if (run) begin
          state_d   = REQUEST;
          memAddr_d = redirOk ? redirectTarget : pcValue;
        end
      end
      REQUEST: begin
        if (redirBad) begin
          fault_d = 1'b1;
          state_d = memReady ? FAULT : DRAIN;
        end else if (redirOk) begin
          // A live request cannot be withdrawn; wait it out in DRAIN.
          if (memReady) memAddr_d = redirectTarget;
          else          state_d   = DRAIN;
        end else if (memReady) begin
          instrData_d = memData;
          instrPc_d   = memAddr_q;
          count_d     = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (redirBad) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else if (redirOk || instrReady) begin
          if (run) begin
            state_d   = REQUEST;
            memAddr_d = redirOk ? redirectTarget : pcValue;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (redirBad) fault_d = 1'b1;
        if (memReady) begin
          // pcValue lags a same-cycle redirect by one edge.
          if (fault_d) begin
            state_d = FAULT;
          end else if (run) begin
            state_d   = REQUEST;
            memAddr_d = redirOk ? redirectTarget : pcValue;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FAULT: ;
      default: state_d = IDLE;
    endcase
  end

  assign pcDataIn      = redirectTarget;
  assign pcWriteEnable = !reset && redirOk && (state_q != FAULT);
  assign pcCountEnable = !reset && count_d;
  assign memValid      = (state_q == REQUEST) || (state_q == DRAIN);
  assign memAddr       = memAddr_q;
  assign instrValid    = (state_q == HOLD);
  assign instrData     = instrData_q;
  assign instrPc       = instrPc_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic
// checked against an instruction-stream reference model.
module tb_fetch_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, run, memReady, instrReady, redirectValid;
  logic [AW-1:0] pcValue, pcDataIn, memAddr, instrPc, redirectTarget;
  logic [DW-1:0] memData, instrData;
  logic          pcWriteEnable, pcCountEnable, memValid;
  logic          instrValid, fault;
  logic [AW-1:0] pc_q;
  int            checks = 0;
  int            failures = 0;

  fetch_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .run(run), .pcValue(pcValue),
    .pcDataIn(pcDataIn), .pcWriteEnable(pcWriteEnable),
    .pcCountEnable(pcCountEnable), .memValid(memValid),
    .memAddr(memAddr), .memReady(memReady), .memData(memData),
    .instrValid(instrValid), .instrData(instrData),
    .instrPc(instrPc), .instrReady(instrReady),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Environment: the PC register and a memory returning memfn(addr).
  always @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else if (pcWriteEnable) pc_q <= pcDataIn;
    else if (pcCountEnable) pc_q <= pc_q + 32'd4;
  end
  assign pcValue = pc_q;
  assign memData = memfn(memAddr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; run = 1'b0; memReady = 1'b0; instrReady = 1'b0;
    redirectValid = 1'b0; redirectTarget = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b1; memReady = 1'b1; instrReady = 1'b1;
    redirectValid = 1'b1; redirectTarget = 32'h40;
    #2;
    checks++;
    if (memValid !== 1'b0 || instrValid !== 1'b0 || fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids mv=%b iv=%b f=%b exp 0 0 0",
               memValid, instrValid, fault);
    end
    checks++;
    if (memAddr !== '0 || instrPc !== '0 || instrData !== '0) begin
      failures++;
      $display("FAIL reset_regs addr=%h ipc=%h idata=%h exp 0",
               memAddr, instrPc, instrData);
    end
    checks++;
    if (pcWriteEnable !== 1'b0 || pcCountEnable !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes we=%b ce=%b exp 0 0",
               pcWriteEnable, pcCountEnable);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; run = 1'b0; memReady = 1'b0; instrReady = 1'b0;
    redirectValid = 1'b0;
  endtask

  task automatic test_sequential;
    logic [AW-1:0] a;
    apply_reset();
    run = 1'b1; memReady = 1'b1; instrReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = AW'(4 * k);
      tick();
      checks++;
      if (memValid !== 1'b1 || memAddr !== a || pcCountEnable !== 1'b1
          || instrValid !== 1'b0) begin
        failures++;
        $display("FAIL seq_req k=%0d mv=%b addr=%h ce=%b iv=%b exp 1 %h 1 0",
                 k, memValid, memAddr, pcCountEnable, instrValid, a);
      end
      tick();
      checks++;
      if (instrValid !== 1'b1 || instrPc !== a || instrData !== memfn(a)
          || memValid !== 1'b0 || pcCountEnable !== 1'b0) begin
        failures++;
        $display("FAIL seq_hold k=%0d iv=%b ipc=%h d=%h mv=%b ce=%b exp pc %h",
                 k, instrValid, instrPc, instrData, memValid,
                 pcCountEnable, a);
      end
    end
  endtask

  task automatic test_mem_stall;
    int pulses;
    apply_reset();
    redirectValid = 1'b1; redirectTarget = 32'h10;
    tick();
    redirectValid = 1'b0;
    checks++;
    if (pcValue !== 32'h10) begin
      failures++;
      $display("FAIL stall_pcload pc=%h exp 00000010", pcValue);
    end
    run = 1'b1; memReady = 1'b0; instrReady = 1'b0; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      memReady = (i == 3);
      #1;
      checks++;
      if (memValid !== 1'b1 || memAddr !== 32'h10 || instrValid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold i=%0d mv=%b addr=%h iv=%b exp 1 10 0",
                 i, memValid, memAddr, instrValid);
      end
      if (pcCountEnable) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL stall_count pulses=%0d exp 1", pulses);
    end
    tick();
    memReady = 1'b0;
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h10
        || instrData !== memfn(32'h10)) begin
      failures++;
      $display("FAIL stall_data iv=%b ipc=%h d=%h exp 1 10 %h",
               instrValid, instrPc, instrData, memfn(32'h10));
    end
  endtask

  task automatic test_redirect_hold;
    redirectValid = 1'b1; redirectTarget = 32'h100;
    instrReady = 1'b1; run = 1'b1;
    #1;
    checks++;
    if (pcWriteEnable !== 1'b1 || pcCountEnable !== 1'b0
        || pcDataIn !== 32'h100) begin
      failures++;
      $display("FAIL redir_hold_strobe we=%b ce=%b din=%h exp 1 0 100",
               pcWriteEnable, pcCountEnable, pcDataIn);
    end
    tick();
    redirectValid = 1'b0; instrReady = 1'b0;
    checks++;
    if (instrValid !== 1'b0 || memValid !== 1'b1 || memAddr !== 32'h100
        || pcValue !== 32'h100) begin
      failures++;
      $display("FAIL redir_hold_next iv=%b mv=%b addr=%h pc=%h exp 0 1 100 100",
               instrValid, memValid, memAddr, pcValue);
    end
  endtask

  task automatic test_redirect_drain;
    logic saw_iv;
    memReady = 1'b0;
    redirectValid = 1'b1; redirectTarget = 32'h200;
    #1;
    checks++;
    if (pcWriteEnable !== 1'b1) begin
      failures++;
      $display("FAIL drain_we we=%b exp 1", pcWriteEnable);
    end
    tick();
    redirectValid = 1'b0;
    saw_iv = instrValid;
    checks++;
    if (memValid !== 1'b1 || memAddr !== 32'h100) begin
      failures++;
      $display("FAIL drain_hold mv=%b addr=%h exp 1 100", memValid, memAddr);
    end
    tick();
    saw_iv |= instrValid;
    memReady = 1'b1;
    #1;
    checks++;
    if (pcCountEnable !== 1'b0) begin
      failures++;
      $display("FAIL drain_count ce=%b exp 0", pcCountEnable);
    end
    tick();
    saw_iv |= instrValid;
    memReady = 1'b0;
    checks++;
    if (saw_iv !== 1'b0 || memValid !== 1'b1 || memAddr !== 32'h200) begin
      failures++;
      $display("FAIL drain_exit stale_iv=%b mv=%b addr=%h exp 0 1 200",
               saw_iv, memValid, memAddr);
    end
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    checks++;
    if (instrValid !== 1'b1 || instrPc !== 32'h200
        || instrData !== memfn(32'h200)) begin
      failures++;
      $display("FAIL drain_fetch iv=%b ipc=%h d=%h exp 1 200 %h",
               instrValid, instrPc, instrData, memfn(32'h200));
    end
  endtask

  task automatic test_fault;
    redirectValid = 1'b1; redirectTarget = 32'h102;
    instrReady = 1'b1; run = 1'b1; memReady = 1'b1;
    #1;
    checks++;
    if (pcWriteEnable !== 1'b0) begin
      failures++;
      $display("FAIL fault_we we=%b exp 0", pcWriteEnable);
    end
    tick();
    redirectValid = 1'b0;
    checks++;
    if (fault !== 1'b1 || instrValid !== 1'b0 || memValid !== 1'b0) begin
      failures++;
      $display("FAIL fault_enter f=%b iv=%b mv=%b exp 1 0 0",
               fault, instrValid, memValid);
    end
    for (int i = 0; i < 5; i++) begin
      redirectValid = 1'b1; redirectTarget = 32'h300;
      #1;
      checks++;
      if (pcWriteEnable !== 1'b0 || pcCountEnable !== 1'b0) begin
        failures++;
        $display("FAIL fault_strobes i=%0d we=%b ce=%b exp 0 0",
                 i, pcWriteEnable, pcCountEnable);
      end
      tick();
      checks++;
      if (memValid !== 1'b0 || instrValid !== 1'b0 || fault !== 1'b1) begin
        failures++;
        $display("FAIL fault_stay i=%0d mv=%b iv=%b f=%b exp 0 0 1",
                 i, memValid, instrValid, fault);
      end
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (fault !== 1'b0 || memValid !== 1'b0 || instrValid !== 1'b0
        || memAddr !== '0 || instrPc !== '0 || instrData !== '0
        || pcWriteEnable !== 1'b0) begin
      failures++;
      $display("FAIL fault_reset f=%b mv=%b iv=%b a=%h ipc=%h d=%h we=%b exp 0",
               fault, memValid, instrValid, memAddr, instrPc, instrData,
               pcWriteEnable);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; redirectValid = 1'b0; run = 1'b0;
    memReady = 1'b0; instrReady = 1'b0;
  endtask

  task automatic test_run_drop;
    apply_reset();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    checks++;
    if (memValid !== 1'b1 || memAddr !== '0) begin
      failures++;
      $display("FAIL rundrop_req mv=%b addr=%h exp 1 0", memValid, memAddr);
    end
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    tick();
    checks++;
    if (instrValid !== 1'b1 || instrPc !== '0 || instrData !== memfn('0)) begin
      failures++;
      $display("FAIL rundrop_deliver iv=%b ipc=%h d=%h exp 1 0 %h",
               instrValid, instrPc, instrData, memfn('0));
    end
    instrReady = 1'b1;
    tick();
    instrReady = 1'b0;
    tick();
    checks++;
    if (memValid !== 1'b0 || instrValid !== 1'b0) begin
      failures++;
      $display("FAIL rundrop_idle mv=%b iv=%b exp 0 0", memValid, instrValid);
    end
    run = 1'b1;
    tick();
    checks++;
    if (memValid !== 1'b1 || memAddr !== 32'h4) begin
      failures++;
      $display("FAIL rundrop_resume mv=%b addr=%h exp 1 4", memValid, memAddr);
    end
  endtask

  // Model: the delivered stream is consecutive words from the last
  // accepted redirect; a misaligned redirect ends all activity.
  task automatic test_random;
    logic [AW-1:0] exp_pc, prev_ma, prev_ip;
    logic          mflt, stopped, prev_mv, prev_mr;
    logic          prev_iv, prev_ir, prev_rv;
    int            r, deliv;
    deliv = 0;
    for (int seg = 0; seg < 6; seg++) begin
      apply_reset();
      exp_pc = '0; mflt = 1'b0; stopped = 1'b0;
      prev_mv = 1'b0; prev_mr = 1'b0; prev_iv = 1'b0;
      prev_ir = 1'b0; prev_rv = 1'b0; prev_ma = '0; prev_ip = '0;
      for (int c = 0; c < 300; c++) begin
        if (c > 0) tick();
        checks++;
        if (fault !== mflt) begin
          failures++;
          $display("FAIL rnd_fault seg=%0d c=%0d f=%b exp %b",
                   seg, c, fault, mflt);
        end
        if (mflt && !memValid) stopped = 1'b1;
        if (mflt) begin
          checks++;
          if (instrValid !== 1'b0 || (stopped && memValid !== 1'b0)) begin
            failures++;
            $display("FAIL rnd_faultquiet c=%0d iv=%b mv=%b exp 0",
                     c, instrValid, memValid);
          end
        end
        if (prev_mv && !prev_mr) begin
          checks++;
          if (memValid !== 1'b1 || memAddr !== prev_ma) begin
            failures++;
            $display("FAIL rnd_memhold c=%0d mv=%b addr=%h exp 1 %h",
                     c, memValid, memAddr, prev_ma);
          end
        end
        if (prev_iv && !prev_ir && !prev_rv) begin
          checks++;
          if (instrValid !== 1'b1 || instrPc !== prev_ip) begin
            failures++;
            $display("FAIL rnd_instrhold c=%0d iv=%b ipc=%h exp 1 %h",
                     c, instrValid, instrPc, prev_ip);
          end
        end
        run = ($urandom_range(0, 9) < 8);
        memReady = $urandom_range(0, 1);
        instrReady = ($urandom_range(0, 9) < 6);
        r = $urandom_range(0, 399);
        redirectValid = (r < 30);
        redirectTarget = AW'({$urandom_range(0, 255), 2'b00});
        if (r == 0) redirectTarget[1:0] = 2'($urandom_range(1, 3));
        #1;
        if (!mflt) begin
          checks++;
          if (pcWriteEnable !== (redirectValid
                                 && redirectTarget[1:0] == 2'b00)) begin
            failures++;
            $display("FAIL rnd_we c=%0d we=%b rv=%b tgt=%h",
                     c, pcWriteEnable, redirectValid, redirectTarget);
          end
        end
        if (redirectValid) begin
          if (!mflt) begin
            if (redirectTarget[1:0] == 2'b00) exp_pc = redirectTarget;
            else mflt = 1'b1;
          end
        end else if (instrValid && instrReady) begin
          checks++;
          if (instrPc !== exp_pc || instrData !== memfn(exp_pc)) begin
            failures++;
            $display("FAIL rnd_deliver c=%0d ipc=%h d=%h exp %h %h",
                     c, instrPc, instrData, exp_pc, memfn(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
          deliv++;
        end
        prev_mv = memValid; prev_mr = memReady; prev_ma = memAddr;
        prev_iv = instrValid; prev_ir = instrReady;
        prev_rv = redirectValid; prev_ip = instrPc;
      end
    end
    checks++;
    if (deliv < 50) begin
      failures++;
      $display("FAIL rnd_progress delivered=%0d exp >=50", deliv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_mem_stall();
    test_redirect_hold();
    test_redirect_drain();
    test_fault();
    test_run_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
